pim_shift_accumulator: RTL and testbench
========================================

Name: pim_shift_accumulator

Overview:
- Downstream stage of the PIM crossbar conv tile.
- Consumes the signed ADC_P-bit partial sum the tile produces for each bit plane of a bit-serially applied multi-bit activation, and shift-adds those partial sums into one dot-product result.
- Presents the result on a valid/ready output toward the next layer (activation/pooling or a further qadd tree).
- Carries bit-plane sequencing state, so the upstream driver only streams beats.

Parameters:
- ADC_P, 8, width of each signed partial sum from the crossbar ADC.
- IN_BITS, 8, number of activation bit planes per result (>=2).
- OUT_W, 16, width of the signed result; internal accumulator is ADC_P+IN_BITS bits.
- SIGNED_IN, 1, 1 = activations are two's complement, so the MSB plane carries negative weight; 0 = unsigned.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  partial sum beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  ADC_P  signed partial sum, one bit plane, MSB plane first.
- flush  input  1  synchronous abort of the current accumulation.
- plane_idx  output  clog2(IN_BITS)  index of the next plane expected (0 = MSB plane).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  OUT_W  signed result, saturated to OUT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; acc=0; plane count=0.
  - out_valid=0, out_data=0, plane_idx=0, in_ready=1.
- States: IDLE, ACCUM, HOLD.
- Beat accepted when in_valid && in_ready.
- IDLE:
  - Accepted beat: acc = SIGNED_IN ? -sext(in_data) : sext(in_data); count=1; go to ACCUM.
- ACCUM:
  - Accepted beat: acc = (acc<<1) + sext(in_data); count++.
  - On the beat where count reaches IN_BITS: register out_data = sat(new acc), set out_valid=1, go to HOLD.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- HOLD:
  - out_valid=1 and out_data are stable until out_ready=1.
  - in_ready = out_ready, so a new result's MSB beat may be accepted in the same cycle the result is taken.
  - out_ready=1 and no beat: go to IDLE, out_valid=0.
  - out_ready=1 and a beat accepted: treat the beat as the IDLE first-beat and go to ACCUM. No bubble.
- in_ready is 1 in IDLE and ACCUM.
- Accumulator width and saturation:
  - Accumulator is ADC_P+IN_BITS signed; no internal overflow is possible.
  - sat(): clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when OUT_W < ADC_P+IN_BITS; otherwise sign-extend.
- flush=1:
  - acc and count go to 0, state to IDLE, out_valid=0 next cycle.
  - A beat presented in the same cycle is dropped. flush has priority over all other events, including a pending HOLD result.
- plane_idx equals count, and reads 0 in IDLE and HOLD.
- in_valid=0 gaps mid-accumulation are allowed: state and acc hold indefinitely.
- Reset asserted mid-accumulation or in HOLD discards everything. The first beat after reset is a new MSB plane.

Test Plan:
1. IN_BITS=4, ADC_P=8, OUT_W=12, SIGNED_IN=1; beats 3,1,0,2 back-to-back, out_ready=1 -> out_valid pulses one cycle after the 4th beat; out_data=-18 (0xFEE); plane_idx sequence 0,1,2,3,0.
2. Same config with SIGNED_IN=0, beats 3,1,0,2 -> out_data=30; beats -1,-1,-1,-1 -> out_data=-15.
3. OUT_W=8, IN_BITS=4, SIGNED_IN=0, beats 127,127,127,127 -> out_data=127 (saturated from 1905); beats -128 x4 -> out_data=-128.
4. Backpressure, config 1: out_ready=0 for 5 cycles after result -> out_valid and out_data=-18 stable, in_ready=0 throughout. Then out_ready=1 with next beats 0,0,0,1 present -> first beat accepted the same cycle; next out_data=1; no bubble cycles.
5. Gaps and flush, config 1: beats 3 and 1, then in_valid=0 for 3 cycles -> plane_idx holds at 2. Then flush=1 with in_valid=1 -> beat dropped, plane_idx=0. New beats 0,0,0,5 -> out_data=5.
6. Assert rst low asynchronously (mid clock) after 2 beats -> out_valid=0, plane_idx=0 immediately. After release, beats 1,0,0,0 -> out_data=-8.

Source files
------------

// File: rtl/pim_shift_accumulator.sv
// Bit-serial shift-accumulator for PIM crossbar partial sums: MSB plane first,
// shift-adds IN_BITS signed ADC beats into one saturated result on a valid/ready output.
module pim_shift_accumulator #(
  parameter int ADC_P     = 8,
  parameter int IN_BITS   = 8,
  parameter int OUT_W     = 16,
  parameter int SIGNED_IN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADC_P-1:0]           in_data,
  input  logic                       flush,
  output logic [$clog2(IN_BITS)-1:0] plane_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data
);

  localparam int ACC_W = ADC_P + IN_BITS;
  localparam int PW    = $clog2(IN_BITS);
  localparam int CW    = $clog2(IN_BITS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_W-1:0]          out_data_q, out_data_d;

  logic                      accept;
  logic signed [ACC_W-1:0]   beat_ext;
  logic signed [ACC_W-1:0]   first_acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic [OUT_W-1:0]          sat_val;

  assign beat_ext  = ACC_W'($signed(in_data));
  // MSB plane of a two's complement activation carries negative weight
  assign first_acc = (SIGNED_IN != 0) ? -beat_ext : beat_ext;
  assign acc_next  = (acc_q <<< 1) + beat_ext;

  generate
    if (OUT_W < ACC_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      assign sat_val = (acc_next > MAXV) ? MAXV[OUT_W-1:0] :
                       (acc_next < MINV) ? MINV[OUT_W-1:0] : acc_next[OUT_W-1:0];
    end else begin : g_ext
      assign sat_val = OUT_W'(acc_next);
    end
  endgenerate

  assign in_ready  = (state_q == HOLD) ? out_ready : 1'b1;
  assign accept    = in_valid && in_ready;
  assign plane_idx = cnt_q[PW-1:0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = first_acc;
            cnt_d   = CW'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(IN_BITS - 1)) begin
              out_data_d  = sat_val;
              out_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          // Result handoff and next MSB beat can share a cycle
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (accept) begin
              acc_d   = first_acc;
              cnt_d   = CW'(1);
              state_d = ACCUM;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pim_shift_accumulator.sv
// Directed bench for pim_shift_accumulator across three parameter sets.
module tb_pim_shift_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // k=0: signed, OUT_W=12; k=1: unsigned, OUT_W=12; k=2: unsigned, OUT_W=8
  logic v0 = 0, v1 = 0, v2 = 0;
  logic f0 = 0, f1 = 0, f2 = 0;
  logic or0 = 1, or1 = 1, or2 = 1;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic ir0, ir1, ir2, ov0, ov1, ov2;
  logic [1:0] pi0, pi1, pi2;
  logic signed [11:0] od0, od1;
  logic signed [7:0]  od2;

  pim_shift_accumulator #(.ADC_P(8), .IN_BITS(4), .OUT_W(12), .SIGNED_IN(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_data(d0), .flush(f0),
    .plane_idx(pi0), .out_valid(ov0), .out_ready(or0), .out_data(od0));
  pim_shift_accumulator #(.ADC_P(8), .IN_BITS(4), .OUT_W(12), .SIGNED_IN(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1), .flush(f1),
    .plane_idx(pi1), .out_valid(ov1), .out_ready(or1), .out_data(od1));
  pim_shift_accumulator #(.ADC_P(8), .IN_BITS(4), .OUT_W(8), .SIGNED_IN(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2), .flush(f2),
    .plane_idx(pi2), .out_valid(ov2), .out_ready(or2), .out_data(od2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic vld, input logic [7:0] dat,
                       input logic fl, input logic ordy);
    case (k)
      0: begin v0 = vld; d0 = dat; f0 = fl; or0 = ordy; end
      1: begin v1 = vld; d1 = dat; f1 = fl; or1 = ordy; end
      default: begin v2 = vld; d2 = dat; f2 = fl; or2 = ordy; end
    endcase
  endtask

  function automatic logic signed [15:0] get_od(input int k);
    case (k)
      0: return 16'(od0);
      1: return 16'(od1);
      default: return 16'(od2);
    endcase
  endfunction

  function automatic logic get_ov(input int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction

  function automatic logic get_ir(input int k);
    return (k == 0) ? ir0 : (k == 1) ? ir1 : ir2;
  endfunction

  function automatic logic [1:0] get_pi(input int k);
    return (k == 0) ? pi0 : (k == 1) ? pi1 : pi2;
  endfunction

  // Streams four back-to-back beats with out_ready=1 and checks result timing/value
  task automatic stream4(input int k, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic signed [15:0] exp, input string nm);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      drive(k, 1'b1, b[i], 1'b0, 1'b1);
      tests++;
      if (get_pi(k) !== 2'(i)) begin
        fails++;
        $display("FAIL %s plane_idx[%0d]: got %0d expected %0d", nm, i, get_pi(k), i);
      end
      tests++;
      if (get_ov(k) !== 1'b0) begin
        fails++;
        $display("FAIL %s early out_valid at beat %0d: got %b expected 0", nm, i, get_ov(k));
      end
      tick();
    end
    drive(k, 1'b0, 8'd0, 1'b0, 1'b1);
    tests++;
    if (get_ov(k) !== 1'b1) begin
      fails++;
      $display("FAIL %s out_valid: got %b expected 1", nm, get_ov(k));
    end
    tests++;
    if (get_od(k) !== exp) begin
      fails++;
      $display("FAIL %s out_data: got %0d expected %0d", nm, get_od(k), exp);
    end
    tests++;
    if (get_pi(k) !== 2'd0) begin
      fails++;
      $display("FAIL %s plane_idx after result: got %0d expected 0", nm, get_pi(k));
    end
    tick();
    tests++;
    if (get_ov(k) !== 1'b0) begin
      fails++;
      $display("FAIL %s out_valid pulse: got %b expected 0", nm, get_ov(k));
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (get_ov(k) !== 1'b0 || get_od(k) !== 16'sd0 || get_pi(k) !== 2'd0 || get_ir(k) !== 1'b1) begin
        fails++;
        $display("FAIL reset dut%0d: got ov=%b od=%0d pi=%0d ir=%b expected 0 0 0 1",
                 k, get_ov(k), get_od(k), get_pi(k), get_ir(k));
      end
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_signed();
    stream4(0, 8'd3, 8'd1, 8'd0, 8'd2, -16'sd18, "signed_3102");
  endtask

  task automatic test_unsigned();
    stream4(1, 8'd3, 8'd1, 8'd0, 8'd2, 16'sd30, "unsigned_3102");
    stream4(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, -16'sd15, "unsigned_neg1");
  endtask

  task automatic test_saturation();
    stream4(2, 8'd127, 8'd127, 8'd127, 8'd127, 16'sd127, "sat_pos");
    stream4(2, 8'h80, 8'h80, 8'h80, 8'h80, -16'sd128, "sat_neg");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [4];
    logic [7:0] c [4];
    a[0] = 8'd3; a[1] = 8'd1; a[2] = 8'd0; a[3] = 8'd2;
    c[0] = 8'd0; c[1] = 8'd0; c[2] = 8'd0; c[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, a[i], 1'b0, 1'b0);
      tick();
    end
    drive(0, 1'b1, c[0], 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      #0;
      tests++;
      if (ov0 !== 1'b1 || od0 !== -12'sd18 || ir0 !== 1'b0 || pi0 !== 2'd0) begin
        fails++;
        $display("FAIL hold cycle %0d: got ov=%b od=%0d ir=%b pi=%0d expected 1 -18 0 0",
                 s, ov0, od0, ir0, pi0);
      end
      tick();
    end
    drive(0, 1'b1, c[0], 1'b0, 1'b1);
    #1;
    tests++;
    if (ir0 !== 1'b1 || ov0 !== 1'b1) begin
      fails++;
      $display("FAIL handoff: got ir=%b ov=%b expected 1 1", ir0, ov0);
    end
    tick();
    tests++;
    if (ov0 !== 1'b0 || pi0 !== 2'd1) begin
      fails++;
      $display("FAIL no bubble: got ov=%b pi=%0d expected 0 1", ov0, pi0);
    end
    for (int i = 1; i < 4; i++) begin
      drive(0, 1'b1, c[i], 1'b0, 1'b1);
      tick();
    end
    drive(0, 1'b0, 8'd0, 1'b0, 1'b1);
    tests++;
    if (ov0 !== 1'b1 || od0 !== 12'sd1) begin
      fails++;
      $display("FAIL b2b result: got ov=%b od=%0d expected 1 1", ov0, od0);
    end
    tick();
  endtask

  task automatic test_gaps_flush();
    drive(0, 1'b1, 8'd3, 1'b0, 1'b1);
    tick();
    drive(0, 1'b1, 8'd1, 1'b0, 1'b1);
    tick();
    drive(0, 1'b0, 8'd9, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      tick();
      tests++;
      if (pi0 !== 2'd2) begin
        fails++;
        $display("FAIL gap hold %0d: got plane_idx=%0d expected 2", g, pi0);
      end
    end
    drive(0, 1'b1, 8'd7, 1'b1, 1'b1);
    tick();
    tests++;
    if (pi0 !== 2'd0 || ov0 !== 1'b0) begin
      fails++;
      $display("FAIL flush: got pi=%0d ov=%b expected 0 0", pi0, ov0);
    end
    drive(0, 1'b0, 8'd0, 1'b0, 1'b1);
    stream4(0, 8'd0, 8'd0, 8'd0, 8'd5, 16'sd5, "after_flush");
    // Flush must also discard a pending result
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'd1, 1'b0, 1'b0);
      tick();
    end
    drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (ov0 !== 1'b1) begin
      fails++;
      $display("FAIL pre-flush hold: got ov=%b expected 1", ov0);
    end
    tick();
    drive(0, 1'b0, 8'd0, 1'b0, 1'b1);
    tests++;
    if (ov0 !== 1'b0) begin
      fails++;
      $display("FAIL flush in hold: got ov=%b expected 0", ov0);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1'b1, 8'd3, 1'b0, 1'b1);
    tick();
    drive(0, 1'b1, 8'd1, 1'b0, 1'b1);
    tick();
    drive(0, 1'b0, 8'd0, 1'b0, 1'b1);
    #3 rst = 1'b0;
    #1;
    tests++;
    if (ov0 !== 1'b0 || pi0 !== 2'd0) begin
      fails++;
      $display("FAIL async reset: got ov=%b pi=%0d expected 0 0", ov0, pi0);
    end
    #2 rst = 1'b1;
    tick();
    stream4(0, 8'd1, 8'd0, 8'd0, 8'd0, -16'sd8, "after_reset");
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_saturation();
    test_back_to_back();
    test_gaps_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
